i2s_tx_serializer: RTL and testbench

- Parametrised multi-lane I2S transmit serializer running on the audio master clock.
- Accepts one stereo sample per lane per frame over a valid/ready handshake, and derives sclk and lrclk from aud_mclk with an integer divider.
- Shifts data MSB-first in standard I2S format (one-bit delay) on NUM_LANES serial outputs.
- Raises a sticky underflow interrupt when a frame starts with no sample buffered.
- Successor to the single-lane, fixed-format sdata_0_out path.

---
 rtl/i2s_tx_pkg.sv | 16 +
 rtl/i2s_tx_lane_shifter.sv | 38 +++
 rtl/i2s_tx_serializer.sv | 180 ++++++++++++++++++
 tb/tb_i2s_tx_serializer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_tx_pkg.sv
// Shared types, slot-clock constants and parameter sanity check for the I2S transmit serializer.
package i2s_tx_pkg;

    localparam int MAX_SLOT_WIDTH = 32;

    localparam logic LRCLK_LEFT  = 1'b0;
    localparam logic LRCLK_RIGHT = 1'b1;

    typedef logic [MAX_SLOT_WIDTH-1:0] lane_sample_t;

    function automatic bit params_ok(input int data_w, input int slot_w, input int sclk_div);
        return (sclk_div >= 2) && ((sclk_div % 2) == 0) &&
               (slot_w >= data_w) && (slot_w <= MAX_SLOT_WIDTH);
    endfunction

endpackage

// File: rtl/i2s_tx_lane_shifter.sv
// One serial lane: slot-wide MSB-first shift register plus the one-sclk delay flop
// that produces standard I2S timing (bypassed when i_lj is high).
module i2s_tx_lane_shifter #(
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic                  i_lj,
    input  logic [SLOT_WIDTH-1:0] i_data,
    output logic                  o_sdata
);

    logic [SLOT_WIDTH-1:0] r_shift;
    logic                  r_dly;

    // A load is also a falling sclk edge, so the outgoing slot's last bit still moves into the delay flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift <= '0;
            r_dly   <= 1'b0;
        end else if (i_clear) begin
            r_shift <= '0;
            r_dly   <= 1'b0;
        end else if (i_load) begin
            r_dly   <= r_shift[SLOT_WIDTH-1];
            r_shift <= i_data;
        end else if (i_shift) begin
            r_dly   <= r_shift[SLOT_WIDTH-1];
            r_shift <= {r_shift[SLOT_WIDTH-2:0], 1'b0};
        end
    end

    assign o_sdata = i_lj ? r_shift[SLOT_WIDTH-1] : r_dly;

endmodule

// File: rtl/i2s_tx_serializer.sv
// Multi-lane I2S transmit serializer clocked by aud_mclk: sclk/lrclk divider, sample handshake,
// underflow interrupt. Define I2S_TX_LJ_MODE_EN to add the lj_mode input (left-justified format).
module i2s_tx_serializer
    import i2s_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int NUM_LANES  = 2,
    parameter int SCLK_DIV   = 4
) (
    input  logic                            aud_mclk,
    input  logic                            aud_mrst,
    input  logic                            en,
    input  logic                            smp_valid,
    output logic                            smp_ready,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] smp_left,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] smp_right,
    input  logic                            irq_en,
    input  logic                            irq_clr,
    output logic                            irq,
    output logic                            sclk_out,
    output logic                            lrclk_out,
    output logic [NUM_LANES-1:0]            sdata_out
`ifdef I2S_TX_LJ_MODE_EN
    ,
    input  logic                            lj_mode
`endif
);

    localparam int DIV_W = $clog2(SCLK_DIV);
    localparam int BIT_W = $clog2(SLOT_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV / 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SLOT_WIDTH - 1);

    if (!params_ok(DATA_WIDTH, SLOT_WIDTH, SCLK_DIV)) begin : g_param_error
        $error("i2s_tx_serializer: SCLK_DIV must be even and >= 2, SLOT_WIDTH in DATA_WIDTH..32");
    end

    function automatic logic [SLOT_WIDTH-1:0] align_slot(input logic [DATA_WIDTH-1:0] d);
        lane_sample_t v;
        v = '0;
        v[MAX_SLOT_WIDTH-1 -: DATA_WIDTH] = d;
        return v[MAX_SLOT_WIDTH-1 -: SLOT_WIDTH];
    endfunction

    logic                            r_run;
    logic [DIV_W-1:0]                r_div_cnt;
    logic [BIT_W-1:0]                r_bit_cnt;
    logic                            r_lrclk;
    logic                            r_sclk;
    logic                            r_hold_valid;
    logic [NUM_LANES*DATA_WIDTH-1:0] r_hold_left;
    logic [NUM_LANES*DATA_WIDTH-1:0] r_hold_right;
    logic [NUM_LANES*DATA_WIDTH-1:0] r_act_right;
    logic                            r_sticky;
    logic                            r_irq;

    logic             w_idle;
    logic             w_start;
    logic             w_fall;
    logic             w_wrap;
    logic             w_frame_load;
    logic             w_right_load;
    logic             w_load;
    logic             w_shift;
    logic             w_accept;
    logic             w_underflow;
    logic             w_lj;
    logic [DIV_W-1:0] w_div_nxt;

    assign w_idle       = !en;
    assign w_start      = en && !r_run;
    assign w_fall       = en && r_run && (r_div_cnt == DIV_LAST);
    assign w_wrap       = w_fall && (r_bit_cnt == BIT_LAST);
    assign w_frame_load = w_start || (w_wrap && (r_lrclk == LRCLK_RIGHT));
    assign w_right_load = w_wrap && (r_lrclk == LRCLK_LEFT);
    assign w_load       = w_frame_load || w_right_load;
    assign w_shift      = w_fall && !w_wrap;
    assign w_accept     = smp_valid && !r_hold_valid;
    assign w_underflow  = w_frame_load && !r_hold_valid;
    assign w_div_nxt    = w_fall ? '0 : r_div_cnt + DIV_W'(1);

`ifdef I2S_TX_LJ_MODE_EN
    assign w_lj = lj_mode;
`else
    assign w_lj = 1'b0;
`endif

    // Bit clock, slot counter and word select; everything parks at zero while disabled.
    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            r_run     <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_lrclk   <= LRCLK_LEFT;
            r_sclk    <= 1'b0;
        end else if (w_idle) begin
            r_run     <= 1'b0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_lrclk   <= LRCLK_LEFT;
            r_sclk    <= 1'b0;
        end else if (!r_run) begin
            r_run     <= 1'b1;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_lrclk   <= LRCLK_LEFT;
            r_sclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_sclk    <= (w_div_nxt >= DIV_HALF);
            if (w_fall) begin
                r_bit_cnt <= w_wrap ? '0 : r_bit_cnt + BIT_W'(1);
            end
            if (w_wrap) begin
                r_lrclk <= ~r_lrclk;
            end
        end
    end

    // Accept only happens while the holding register is empty, so it never collides with a drain.
    always_ff @(posedge aud_mclk or posedge aud_mrst) begin
        if (aud_mrst) begin
            r_hold_valid <= 1'b0;
            r_hold_left  <= '0;
            r_hold_right <= '0;
            r_act_right  <= '0;
            r_sticky     <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold_valid <= 1'b1;
                r_hold_left  <= smp_left;
                r_hold_right <= smp_right;
            end else if (w_frame_load) begin
                r_hold_valid <= 1'b0;
            end
            if (w_frame_load) begin
                r_act_right <= r_hold_valid ? r_hold_right : '0;
            end
            if (w_underflow) begin
                r_sticky <= 1'b1;
            end else if (irq_clr) begin
                r_sticky <= 1'b0;
            end
            r_irq <= r_sticky & irq_en;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [SLOT_WIDTH-1:0] w_load_data;

        always_comb begin
            w_load_data = align_slot(r_act_right[i*DATA_WIDTH +: DATA_WIDTH]);
            if (w_frame_load) begin
                w_load_data = r_hold_valid ? align_slot(r_hold_left[i*DATA_WIDTH +: DATA_WIDTH]) : '0;
            end
        end

        i2s_tx_lane_shifter #(
            .SLOT_WIDTH(SLOT_WIDTH)
        ) u_shifter (
            .i_clk   (aud_mclk),
            .i_rst   (aud_mrst),
            .i_clear (w_idle),
            .i_load  (w_load),
            .i_shift (w_shift),
            .i_lj    (w_lj),
            .i_data  (w_load_data),
            .o_sdata (sdata_out[i])
        );
    end

    assign smp_ready = !r_hold_valid;
    assign sclk_out  = r_sclk;
    assign lrclk_out = r_lrclk;
    assign irq       = r_irq;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Self-checking bench for i2s_tx_serializer: directed frame sequence with random samples,
// checked against a frame-level bitstream model. Define I2S_TX_LJ_MODE_EN to add the LJ step.
module tb_i2s_tx_serializer;

    localparam int DW  = 24;
    localparam int SW  = 32;
    localparam int NL  = 2;
    localparam int DIV = 4;

    logic              aud_mclk = 1'b0;
    logic              aud_mrst;
    logic              en;
    logic              smp_valid;
    logic              smp_ready;
    logic [NL*DW-1:0]  smp_left;
    logic [NL*DW-1:0]  smp_right;
    logic              irq_en;
    logic              irq_clr;
    logic              irq;
    logic              sclk_out;
    logic              lrclk_out;
    logic [NL-1:0]     sdata_out;
`ifdef I2S_TX_LJ_MODE_EN
    logic              lj_mode;
`endif

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: pending samples, last transmitted bit per lane, sticky flag.
    logic [NL*DW-1:0] hq_l[$];
    logic [NL*DW-1:0] hq_r[$];
    bit               prev[NL];
    bit               m_sticky;
    bit               m_clr_pend;
    bit               m_lj;

    i2s_tx_serializer #(
        .DATA_WIDTH(DW),
        .SLOT_WIDTH(SW),
        .NUM_LANES (NL),
        .SCLK_DIV  (DIV)
    ) dut (
        .aud_mclk  (aud_mclk),
        .aud_mrst  (aud_mrst),
        .en        (en),
        .smp_valid (smp_valid),
        .smp_ready (smp_ready),
        .smp_left  (smp_left),
        .smp_right (smp_right),
        .irq_en    (irq_en),
        .irq_clr   (irq_clr),
        .irq       (irq),
        .sclk_out  (sclk_out),
        .lrclk_out (lrclk_out),
        .sdata_out (sdata_out)
`ifdef I2S_TX_LJ_MODE_EN
        ,
        .lj_mode   (lj_mode)
`endif
    );

    always #5 aud_mclk = ~aud_mclk;

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [SW-1:0] align(input logic [DW-1:0] d);
        return SW'(d) << (SW - DW);
    endfunction

    function automatic logic [NL*DW-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[NL*DW-1:0];
    endfunction

    task automatic submit_idle(input logic [NL*DW-1:0] l, input logic [NL*DW-1:0] r);
        smp_valid = 1'b1;
        smp_left  = l;
        smp_right = r;
        @(negedge aud_mclk);
        smp_valid = 1'b0;
        hq_l.push_back(l);
        hq_r.push_back(r);
        chk("ready_after_idle_accept", 32'(smp_ready), 32'(0));
    endtask

    task automatic start_tx();
        en = 1'b1;
        @(negedge aud_mclk);
        for (int l = 0; l < NL; l++) prev[l] = 1'b0;
    endtask

    // Called on the falling mclk edge right after a frame-start load; walks nbits sclk periods.
    task automatic run_frame(input logic [NL*DW-1:0] nl, input logic [NL*DW-1:0] nr,
                             input bit submit, input bit clr_mid, input bit clr_end, input int nbits);
        logic [NL*DW-1:0] fl;
        logic [NL*DW-1:0] fr;
        logic [2*SW-1:0]  fb[NL];
        logic [NL-1:0]    exp_sd;
        if (hq_l.size() == 0) begin
            fl       = '0;
            fr       = '0;
            m_sticky = 1'b1;
        end else begin
            fl = hq_l.pop_front();
            fr = hq_r.pop_front();
            if (m_clr_pend) m_sticky = 1'b0;
        end
        m_clr_pend = 1'b0;
        for (int l = 0; l < NL; l++) fb[l] = {align(fl[l*DW +: DW]), align(fr[l*DW +: DW])};

        for (int k = 0; k < nbits; k++) begin
            chk($sformatf("sclk_low k=%0d", k), 32'(sclk_out), 32'(0));
            if (k == 0) chk("ready_at_load", 32'(smp_ready), 32'(hq_l.size() == 0));
            if (submit && k == 5) begin
                smp_valid = 1'b1;
                smp_left  = nl;
                smp_right = nr;
            end
            if (clr_mid && k == 10) irq_clr = 1'b1;
            @(negedge aud_mclk);
            if (submit && k == 5) begin
                smp_valid = 1'b0;
                hq_l.push_back(nl);
                hq_r.push_back(nr);
                chk("ready_after_accept", 32'(smp_ready), 32'(0));
            end
            if (clr_mid && k == 10) begin
                irq_clr  = 1'b0;
                m_sticky = 1'b0;
            end
            @(negedge aud_mclk);
            for (int l = 0; l < NL; l++) begin
                if (m_lj) exp_sd[l] = fb[l][2*SW-1-k];
                else      exp_sd[l] = (k == 0) ? prev[l] : fb[l][2*SW-k];
            end
            chk($sformatf("sclk_high k=%0d", k), 32'(sclk_out), 32'(1));
            chk($sformatf("lrclk k=%0d", k), 32'(lrclk_out), 32'(k >= SW));
            chk($sformatf("sdata k=%0d", k), 32'(sdata_out), 32'(exp_sd));
            if (k == 2 || k == 40) chk($sformatf("irq k=%0d", k), 32'(irq), 32'(m_sticky & irq_en));
            @(negedge aud_mclk);
            if (clr_end && k == nbits - 1) irq_clr = 1'b1;
            @(negedge aud_mclk);
            irq_clr = 1'b0;
        end
        if (clr_end) m_clr_pend = 1'b1;
        if (nbits == 2*SW) begin
            for (int l = 0; l < NL; l++) prev[l] = fb[l][0];
        end
    endtask

    initial begin
        aud_mrst  = 1'b1;
        en        = 1'b0;
        smp_valid = 1'b0;
        smp_left  = '0;
        smp_right = '0;
        irq_en    = 1'b0;
        irq_clr   = 1'b0;
        m_sticky  = 1'b0;
        m_clr_pend = 1'b0;
        m_lj      = 1'b0;
        for (int l = 0; l < NL; l++) prev[l] = 1'b0;
`ifdef I2S_TX_LJ_MODE_EN
        lj_mode   = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge aud_mclk);
        chk("rst_sclk", 32'(sclk_out), 32'(0));
        chk("rst_lrclk", 32'(lrclk_out), 32'(0));
        chk("rst_sdata", 32'(sdata_out), 32'(0));
        chk("rst_irq", 32'(irq), 32'(0));
        chk("rst_ready", 32'(smp_ready), 32'(1));
        aud_mrst = 1'b0;
        irq_en   = 1'b1;
        repeat (4) begin
            @(negedge aud_mclk);
            chk("idle_sclk", 32'(sclk_out), 32'(0));
        end

        // Single directed frame, then back-to-back random frames
        submit_idle({24'h800001, 24'hA5A5A5}, {24'h5A0FF0, 24'h3C3C3C});
        start_tx();
        run_frame(rnd(), rnd(), 1'b1, 1'b0, 1'b0, 2*SW);
        for (int f = 0; f < 10; f++) run_frame(rnd(), rnd(), 1'b1, 1'b0, 1'b0, 2*SW);

        // Stop supplying: one frame drains the last sample, the next ones underflow
        run_frame('0, '0, 1'b0, 1'b0, 1'b0, 2*SW);
        run_frame('0, '0, 1'b0, 1'b0, 1'b1, 2*SW);
        run_frame(rnd(), rnd(), 1'b1, 1'b1, 1'b0, 2*SW);

        // Enable drop at bit 10 of the right slot
        run_frame(rnd(), rnd(), 1'b1, 1'b0, 1'b0, SW + 10);
        en = 1'b0;
        @(negedge aud_mclk);
        chk("endrop_sclk", 32'(sclk_out), 32'(0));
        chk("endrop_lrclk", 32'(lrclk_out), 32'(0));
        chk("endrop_sdata", 32'(sdata_out), 32'(0));
        chk("endrop_hold_kept", 32'(smp_ready), 32'(0));
        repeat (5) @(negedge aud_mclk);
        start_tx();
        run_frame(rnd(), rnd(), 1'b1, 1'b0, 1'b0, 2*SW);

        // Asynchronous reset mid right slot with the holding register full
        run_frame(rnd(), rnd(), 1'b1, 1'b0, 1'b0, SW + 8);
        repeat (2) @(negedge aud_mclk);
        aud_mrst = 1'b1;
        #1;
        chk("amrst_sclk", 32'(sclk_out), 32'(0));
        chk("amrst_lrclk", 32'(lrclk_out), 32'(0));
        chk("amrst_sdata", 32'(sdata_out), 32'(0));
        chk("amrst_irq", 32'(irq), 32'(0));
        chk("amrst_ready", 32'(smp_ready), 32'(1));
        hq_l.delete();
        hq_r.delete();
        m_sticky   = 1'b0;
        m_clr_pend = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge aud_mclk);
        aud_mrst = 1'b0;
        repeat (8) begin
            @(negedge aud_mclk);
            chk("post_rst_sclk", 32'(sclk_out), 32'(0));
            chk("post_rst_sdata", 32'(sdata_out), 32'(0));
        end

`ifdef I2S_TX_LJ_MODE_EN
        // Left-justified frame: MSB coincides with the lrclk edge
        lj_mode = 1'b1;
        m_lj    = 1'b1;
        submit_idle({24'h000000, 24'hFFFFFF}, '0);
        start_tx();
        run_frame(rnd(), rnd(), 1'b1, 1'b0, 1'b0, 2*SW);
        en = 1'b0;
        @(negedge aud_mclk);
        chk("lj_idle_sdata", 32'(sdata_out), 32'(0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
